// File: rtl/signal_delay_prog.sv
// Runtime-programmable delay line for a valid-tagged stream, with a flush FSM that masks
// output valid while a newly loaded delay settles. Optional macro: SIGNAL_DELAY_DROP_CNT_EN.
module signal_delay_prog #(
  parameter int DATAWIDTH     = 32,
  parameter int MAX_DELAY     = 16,
  parameter int DEFAULT_DELAY = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_load,
  input  logic [$clog2(MAX_DELAY):0]   delay_cfg,
  input  logic                         pre_valid,
  input  logic [DATAWIDTH-1:0]         pre_signal,
  output logic                         signal_valid,
  output logic [DATAWIDTH-1:0]         signal,
  output logic                         busy,
  output logic [$clog2(MAX_DELAY):0]   cur_delay,
  output logic [15:0]                  drop_cnt
);

  localparam int PW = $clog2(MAX_DELAY);
  localparam int AW = PW + 1;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [AW-1:0]        flushCnt_q, flushCnt_d;
  logic [AW-1:0]        curDelay_q, curDelay_d;
  logic [PW-1:0]        wrPtr_q;
  logic [PW-1:0]        rdPtr;
  logic [MAX_DELAY-1:0] validTag_q;
  logic [DATAWIDTH-1:0] dataMem_q [MAX_DELAY];
  logic                 rdValid;
  logic [DATAWIDTH-1:0] rdData;
  logic                 masked;
  logic                 signalValid_q, signalValid_d;
  logic [DATAWIDTH-1:0] signal_q, signal_d;
  logic [AW-1:0]        loadDelay;

  function automatic logic [AW-1:0] clampDelay(input logic [AW-1:0] d);
    if (d == '0)
      return AW'(1);
    else if (d > AW'(MAX_DELAY))
      return AW'(MAX_DELAY);
    else
      return d;
  endfunction

  // Modulo-MAX_DELAY subtraction; at D=MAX_DELAY this is the slot about to be overwritten.
  assign rdPtr     = wrPtr_q - curDelay_q[PW-1:0];
  assign rdValid   = validTag_q[rdPtr];
  assign rdData    = dataMem_q[rdPtr];
  assign loadDelay = clampDelay(delay_cfg);

  always_comb begin
    state_d    = state_q;
    flushCnt_d = flushCnt_q;
    curDelay_d = curDelay_q;
    if (cfg_load) begin
      state_d    = ST_FLUSH;
      flushCnt_d = loadDelay;
      curDelay_d = loadDelay;
    end else if (state_q == ST_FLUSH) begin
      if (flushCnt_q <= AW'(1)) begin
        state_d    = ST_RUN;
        flushCnt_d = '0;
      end else begin
        flushCnt_d = flushCnt_q - AW'(1);
      end
    end
  end

  // Masking follows the next state so busy and the suppressed valids line up cycle for cycle.
  assign masked = (state_d == ST_FLUSH);

  always_comb begin
    signalValid_d = 1'b0;
    signal_d      = signal_q;
    if (!masked) begin
      signalValid_d = rdValid;
      signal_d      = rdData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      flushCnt_q    <= '0;
      curDelay_q    <= AW'(DEFAULT_DELAY);
      wrPtr_q       <= '0;
      validTag_q    <= '0;
      signalValid_q <= 1'b0;
      signal_q      <= '0;
    end else begin
      state_q             <= state_d;
      flushCnt_q          <= flushCnt_d;
      curDelay_q          <= curDelay_d;
      wrPtr_q             <= wrPtr_q + PW'(1);
      validTag_q[wrPtr_q] <= pre_valid;
      signalValid_q       <= signalValid_d;
      signal_q            <= signal_d;
    end
  end

  always_ff @(posedge clk) begin
    dataMem_q[wrPtr_q] <= pre_signal;
  end

  assign signal_valid = signalValid_q;
  assign signal       = signal_q;
  assign busy         = (state_q == ST_FLUSH);
  assign cur_delay    = curDelay_q;

`ifdef SIGNAL_DELAY_DROP_CNT_EN
  logic [15:0] dropCnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dropCnt_q <= '0;
    else if (masked && rdValid && (dropCnt_q != 16'hFFFF))
      dropCnt_q <= dropCnt_q + 16'd1;
  end

  assign drop_cnt = dropCnt_q;
`else
  assign drop_cnt = 16'h0000;
`endif

endmodule
